// File: rtl/veri_risc_pkg.sv
// Shared definitions for the VeriRISC accumulator CPU: widths, opcodes, phases.
package veri_risc_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Eight controller phases; every instruction walks through all of them.
  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand and load the accumulator.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/veri_risc_controller.sv
// Eight-phase sequencer with control-strobe decode; freezes in OP_ADDR on HLT.
module veri_risc_controller
  import veri_risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode_i,
  input  logic       zero_i,
  output logic       sel_o,
  output logic       rd_o,
  output logic       ld_ir_o,
  output logic       ld_ac_o,
  output logic       ld_pc_o,
  output logic       inc_pc_o,
  output logic       wr_o,
  output logic       data_e_o,
  output logic       halt_o
);

  phase_e state_q, state_d;
  logic   alu_op;

  assign alu_op = is_alu_op(opcode_i);

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PH_INST_ADDR;
    else     state_q <= state_d;
  end

  // Next phase and strobes for the current phase.
  always_comb begin
    state_d  = state_q;
    sel_o    = 1'b0;
    rd_o     = 1'b0;
    ld_ir_o  = 1'b0;
    ld_ac_o  = 1'b0;
    ld_pc_o  = 1'b0;
    inc_pc_o = 1'b0;
    wr_o     = 1'b0;
    data_e_o = 1'b0;
    halt_o   = 1'b0;
    case (state_q)
      PH_INST_ADDR: begin
        state_d = PH_INST_FETCH;
      end
      PH_INST_FETCH: begin
        rd_o    = 1'b1;
        state_d = PH_INST_LOAD;
      end
      PH_INST_LOAD: begin
        rd_o    = 1'b1;
        ld_ir_o = 1'b1;
        state_d = PH_IDLE;
      end
      PH_IDLE: begin
        rd_o    = 1'b1;
        ld_ir_o = 1'b1;
        state_d = PH_OP_ADDR;
      end
      PH_OP_ADDR: begin
        sel_o = 1'b1;
        if (opcode_i == OP_HLT) begin
          halt_o  = 1'b1;
          state_d = PH_OP_ADDR;
        end else begin
          inc_pc_o = 1'b1;
          state_d  = PH_OP_FETCH;
        end
      end
      PH_OP_FETCH: begin
        sel_o   = 1'b1;
        rd_o    = alu_op;
        state_d = PH_ALU_OP;
      end
      PH_ALU_OP: begin
        sel_o    = 1'b1;
        rd_o     = alu_op;
        inc_pc_o = (opcode_i == OP_SKZ) && zero_i;
        ld_pc_o  = (opcode_i == OP_JMP);
        data_e_o = (opcode_i == OP_STO);
        state_d  = PH_STORE;
      end
      PH_STORE: begin
        sel_o    = 1'b1;
        rd_o     = alu_op;
        ld_ac_o  = alu_op;
        ld_pc_o  = (opcode_i == OP_JMP);
        wr_o     = (opcode_i == OP_STO);
        data_e_o = (opcode_i == OP_STO);
        state_d  = PH_INST_ADDR;
      end
      default: begin
        state_d = PH_INST_ADDR;
      end
    endcase
  end

endmodule

// File: rtl/veri_risc_memory.sv
// 32x8 unified instruction/data memory: synchronous write, combinational read.
module veri_risc_memory
  import veri_risc_pkg::*;
(
  input  logic              clk,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:31];

  // Write port: store the data bus on the rising edge when wr is high.
  always_ff @(posedge clk) begin
    if (wr_i) mem[addr_i] <= wdata_i;
  end

  // Read port: data only driven onto the bus while the controller asks for it.
  always_comb begin
    rdata_o = rd_i ? mem[addr_i] : '0;
  end

endmodule

// File: rtl/veri_risc.sv
// VeriRISC top: PC, IR, AC, ALU and address mux around controller and memory.
module veri_risc
  import veri_risc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic halt
);

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ac_q;

  logic [2:0]        opcode;
  logic              zero;
  logic              sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data_bus;
  logic [DATA_W-1:0] alu_result;

  assign opcode   = ir_q[7:5];
  assign zero     = (ac_q == '0);
  assign mem_addr = sel ? ir_q[ADDR_W-1:0] : pc_q;
  assign data_bus = data_e ? ac_q : '0;

  // ALU: result loaded into AC at the end of an ALU-op instruction.
  always_comb begin
    alu_result = ac_q;
    case (opcode)
      OP_ADD:  alu_result = ac_q + mem_rdata;
      OP_AND:  alu_result = ac_q & mem_rdata;
      OP_XOR:  alu_result = ac_q ^ mem_rdata;
      OP_LDA:  alu_result = mem_rdata;
      default: alu_result = ac_q;
    endcase
  end

  // Program counter: a jump load wins over increment; wraps naturally at 31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc_q <= '0;
    else if (ld_pc)  pc_q <= ir_q[ADDR_W-1:0];
    else if (inc_pc) pc_q <= pc_q + 1'b1;
  end

  // Instruction and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
      ac_q <= '0;
    end else begin
      if (ld_ir) ir_q <= mem_rdata;
      if (ld_ac) ac_q <= alu_result;
    end
  end

  veri_risc_controller controller_inst (
    .clk      (clk),
    .rst      (rst),
    .opcode_i (opcode),
    .zero_i   (zero),
    .sel_o    (sel),
    .rd_o     (rd),
    .ld_ir_o  (ld_ir),
    .ld_ac_o  (ld_ac),
    .ld_pc_o  (ld_pc),
    .inc_pc_o (inc_pc),
    .wr_o     (wr),
    .data_e_o (data_e),
    .halt_o   (halt)
  );

  veri_risc_memory memory_inst (
    .clk     (clk),
    .rd_i    (rd),
    .wr_i    (wr),
    .addr_i  (mem_addr),
    .wdata_i (data_bus),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_veri_risc.sv
// Self-checking bench for veri_risc: directed programs plus random straight-line programs
// checked against an instruction-level interpreter.
module tb_veri_risc;

  logic clk;
  logic rst;
  logic halt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] tb_mem    [32];
  logic [7:0] model_mem [32];

  veri_risc dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int op, input int addr);
    logic [7:0] w;
    w = 8'((op << 5) | (addr & 31));
    return w;
  endfunction

  // Program image: everything HLT unless the test overrides it.
  task automatic clear_image();
    for (int i = 0; i < 32; i++) tb_mem[i] = 8'h00;
  endtask

  // Hold reset, copy the image in, release at a falling edge, count rising edges until halt.
  task automatic run_prog(output int halt_edge);
    int edges;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.memory_inst.mem[i] = tb_mem[i];
    @(negedge clk);
    rst = 1'b0;
    edges = 0;
    halt_edge = -1;
    while (edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (halt === 1'b1) begin
        halt_edge = edges;
        break;
      end
    end
  endtask

  // Instruction-level interpreter: returns the edge at which halt should rise and final AC.
  task automatic model_run(output int exp_edge, output logic [7:0] exp_ac);
    int pc;
    logic [7:0] ac;
    logic [7:0] ir;
    int a;
    pc = 0;
    ac = 8'h00;
    exp_edge = -2;
    for (int i = 0; i < 32; i++) model_mem[i] = tb_mem[i];
    for (int step = 0; step < 64; step++) begin
      ir = model_mem[pc];
      a  = int'(ir[4:0]);
      if (ir[7:5] == 3'd0) begin
        exp_edge = 8 * step + 4;
        break;
      end
      pc = (pc + 1) % 32;
      case (ir[7:5])
        3'd1: if (ac == 8'h00) pc = (pc + 1) % 32;
        3'd2: ac = ac + model_mem[a];
        3'd3: ac = ac & model_mem[a];
        3'd4: ac = ac ^ model_mem[a];
        3'd5: ac = model_mem[a];
        3'd6: model_mem[a] = ac;
        default: pc = a;
      endcase
    end
    exp_ac = ac;
  endtask

  task automatic test_reset();
    int he;
    clear_image();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dut.pc_q !== 5'd0 || dut.ir_q !== 8'd0 || dut.ac_q !== 8'd0 ||
        int'(dut.controller_inst.state_q) != 0)
      begin n_bad++; $display("FAIL reset_regs: pc=%0d ir=%h ac=%h phase=%0d required all 0",
                              dut.pc_q, dut.ir_q, dut.ac_q, int'(dut.controller_inst.state_q)); end
    run_prog(he);
    n_cmp++;
    if (he !== 4) begin n_bad++; $display("FAIL hlt_at_0: halt edge %0d required 4", he); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (halt !== 1'b1) begin n_bad++; $display("FAIL hlt_sticky: halt=%b required 1", halt); end
    $display("test_reset: halt edge %0d", he);
  endtask

  task automatic test_jmp();
    int he, ee;
    logic [7:0] eac;
    clear_image();
    tb_mem[0] = enc(7, 2);
    tb_mem[1] = enc(7, 2);
    tb_mem[2] = enc(0, 0);
    model_run(ee, eac);
    run_prog(he);
    n_cmp++;
    if (he !== 12) begin n_bad++; $display("FAIL jmp_halt: halt edge %0d required 12", he); end
    $display("test_jmp: halt edge %0d (model %0d)", he, ee);
  endtask

  task automatic test_skz();
    int he;
    clear_image();
    tb_mem[0] = enc(1, 0);
    tb_mem[1] = enc(7, 2);
    tb_mem[2] = enc(0, 0);
    run_prog(he);
    n_cmp++;
    if (he !== 12) begin n_bad++; $display("FAIL skz_halt: halt edge %0d required 12", he); end
    $display("test_skz: halt edge %0d", he);
  endtask

  task automatic test_lda_sto();
    int he;
    clear_image();
    tb_mem[0] = enc(5, 7);
    tb_mem[1] = enc(6, 8);
    tb_mem[2] = enc(5, 8);
    tb_mem[3] = enc(1, 0);
    tb_mem[4] = enc(0, 0);
    tb_mem[7] = 8'h01;
    tb_mem[8] = 8'h00;
    run_prog(he);
    n_cmp++;
    if (he !== 36) begin n_bad++; $display("FAIL ldasto_halt: halt edge %0d required 36", he); end
    n_cmp++;
    if (dut.memory_inst.mem[8] !== 8'h01)
      begin n_bad++; $display("FAIL ldasto_mem8: mem[8]=%h required 01", dut.memory_inst.mem[8]); end
    n_cmp++;
    if (dut.ac_q !== 8'h01) begin n_bad++; $display("FAIL ldasto_ac: ac=%h required 01", dut.ac_q); end
    $display("test_lda_sto: halt edge %0d mem[8]=%h", he, dut.memory_inst.mem[8]);
  endtask

  // Shared shape for AND/XOR: first result non-zero (stored to 20), second zero (SKZ skips a HLT).
  task automatic test_logic(input int op, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] r1);
    int he;
    clear_image();
    tb_mem[0] = enc(5, 16);
    tb_mem[1] = enc(op, 17);
    tb_mem[2] = enc(1, 0);
    tb_mem[3] = enc(6, 20);
    tb_mem[4] = enc(op, 18);
    tb_mem[5] = enc(1, 0);
    tb_mem[6] = enc(0, 0);
    tb_mem[7] = enc(6, 21);
    tb_mem[8] = enc(0, 0);
    tb_mem[16] = a0;
    tb_mem[17] = a1;
    tb_mem[18] = a2;
    tb_mem[20] = 8'hAA;
    tb_mem[21] = 8'hAA;
    run_prog(he);
    n_cmp++;
    if (he !== 60) begin n_bad++; $display("FAIL logic%0d_halt: halt edge %0d required 60", op, he); end
    n_cmp++;
    if (dut.memory_inst.mem[20] !== r1)
      begin n_bad++; $display("FAIL logic%0d_first: mem[20]=%h required %h", op, dut.memory_inst.mem[20], r1); end
    n_cmp++;
    if (dut.memory_inst.mem[21] !== 8'h00)
      begin n_bad++; $display("FAIL logic%0d_zero: mem[21]=%h required 00", op, dut.memory_inst.mem[21]); end
    $display("test_logic op%0d: halt edge %0d mem[20]=%h mem[21]=%h", op, he,
             dut.memory_inst.mem[20], dut.memory_inst.mem[21]);
  endtask

  task automatic test_add();
    int he;
    clear_image();
    tb_mem[0] = enc(5, 16);
    tb_mem[1] = enc(2, 17);
    tb_mem[2] = enc(1, 0);
    tb_mem[3] = enc(0, 0);
    tb_mem[4] = enc(2, 17);
    tb_mem[5] = enc(6, 20);
    tb_mem[6] = enc(0, 0);
    tb_mem[16] = 8'hFF;
    tb_mem[17] = 8'h01;
    tb_mem[20] = 8'hAA;
    run_prog(he);
    n_cmp++;
    if (he !== 44) begin n_bad++; $display("FAIL add_halt: halt edge %0d required 44", he); end
    n_cmp++;
    if (dut.memory_inst.mem[20] !== 8'h01)
      begin n_bad++; $display("FAIL add_result: mem[20]=%h required 01", dut.memory_inst.mem[20]); end
    $display("test_add: halt edge %0d mem[20]=%h", he, dut.memory_inst.mem[20]);
  endtask

  task automatic test_reset_mid_sto();
    int he;
    clear_image();
    tb_mem[0]  = enc(5, 20);
    tb_mem[1]  = enc(6, 21);
    tb_mem[2]  = enc(0, 0);
    tb_mem[20] = 8'h5A;
    tb_mem[21] = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.memory_inst.mem[i] = tb_mem[i];
    @(negedge clk);
    rst = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (int'(dut.controller_inst.state_q) != 5)
      begin n_bad++; $display("FAIL midsto_phase: phase=%0d required 5", int'(dut.controller_inst.state_q)); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dut.pc_q !== 5'd0 || halt !== 1'b0 || int'(dut.controller_inst.state_q) != 0)
      begin n_bad++; $display("FAIL midsto_abort: pc=%0d halt=%b phase=%0d required 0/0/0",
                              dut.pc_q, halt, int'(dut.controller_inst.state_q)); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (dut.memory_inst.mem[21] !== 8'h00)
      begin n_bad++; $display("FAIL midsto_nowrite: mem[21]=%h required 00", dut.memory_inst.mem[21]); end
    run_prog(he);
    n_cmp++;
    if (he !== 20) begin n_bad++; $display("FAIL midsto_rerun: halt edge %0d required 20", he); end
    n_cmp++;
    if (dut.memory_inst.mem[21] !== 8'h5A)
      begin n_bad++; $display("FAIL midsto_store: mem[21]=%h required 5a", dut.memory_inst.mem[21]); end
    $display("test_reset_mid_sto: rerun halt edge %0d mem[21]=%h", he, dut.memory_inst.mem[21]);
  endtask

  // Random forward-only programs in 0..k-1, HLT padding to 15, random data in 16..31.
  task automatic test_random(input int n_prog);
    int he, ee, k, op, bad_words;
    logic [7:0] eac;
    for (int p = 0; p < n_prog; p++) begin
      clear_image();
      k = int'($urandom_range(4, 12));
      for (int i = 16; i < 32; i++) tb_mem[i] = 8'($urandom);
      for (int i = 0; i < k; i++) begin
        op = int'($urandom_range(1, 7));
        if (op == 7)      tb_mem[i] = enc(7, int'($urandom_range(i + 1, 15)));
        else if (op == 1) tb_mem[i] = enc(1, int'($urandom_range(0, 31)));
        else              tb_mem[i] = enc(op, int'($urandom_range(16, 31)));
      end
      model_run(ee, eac);
      run_prog(he);
      n_cmp++;
      if (he !== ee) begin n_bad++; $display("FAIL rand%0d_halt: halt edge %0d required %0d", p, he, ee); end
      n_cmp++;
      if (dut.ac_q !== eac) begin n_bad++; $display("FAIL rand%0d_ac: ac=%h required %h", p, dut.ac_q, eac); end
      bad_words = 0;
      for (int i = 0; i < 32; i++) begin
        if (dut.memory_inst.mem[i] !== model_mem[i]) begin
          if (bad_words == 0)
            $display("FAIL rand%0d_mem: mem[%0d]=%h required %h", p, i, dut.memory_inst.mem[i], model_mem[i]);
          bad_words++;
        end
      end
      n_cmp++;
      if (bad_words != 0) n_bad++;
      $display("test_random #%0d: len %0d halt edge %0d (model %0d) ac=%h", p, k, he, ee, dut.ac_q);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_jmp();
    test_skz();
    test_lda_sto();
    test_logic(3, 8'hFF, 8'h01, 8'hFE, 8'h01);
    test_logic(4, 8'h55, 8'h54, 8'h01, 8'h01);
    test_add();
    test_reset_mid_sto();
    test_random(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
